// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data memory bus arbiter:
// FSM state encoding, default widths and the wait counter sizing.
package mem_bus_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_WAIT   = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GNT_I = 3'd1,
        ST_GNT_D = 3'd2,
        ST_ACK_I = 3'd3,
        ST_ACK_D = 3'd4
    } arb_state_t;

    // Wait counter spans 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and
// data load/store ports, data first, with a wait-state access FSM.
//
// Ports:
//   clk, rst           clock, async active-low reset
//   if_req/if_addr     fetch request in; if_rdata/if_ack out
//   d_req/d_we/d_sel   data request, store flag, byte enables
//   d_addr/d_wdata     data address and store data
//   d_rdata/d_ack      load data and completion pulse
//   mem_*              memory strobes, address, data; mem_rdata in
//   stall_o            pipeline stall while any request is pending
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int WAIT_CYCLES = ARB_WAIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_sel,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_we_q;
    logic [SEL_W-1:0]  req_sel_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic in_gnt;
    logic last;

    assign in_gnt = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);
    assign last   = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (d_req)
                    state_d = ST_GNT_D;
                else if (if_req)
                    state_d = ST_GNT_I;
            end
            ST_GNT_I: if (last) state_d = ST_ACK_I;
            ST_GNT_D: if (last) state_d = ST_ACK_D;
            ST_ACK_I: state_d = ST_IDLE;
            ST_ACK_D: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter only advances inside a grant and restarts at every access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (in_gnt && !last) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Requester fields are latched once at grant; the port may change
    // afterwards without disturbing the access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_we_q    <= 1'b0;
            req_sel_q   <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (d_req) begin
                req_we_q    <= d_we;
                req_sel_q   <= d_we ? d_sel : {SEL_W{1'b1}};
                req_addr_q  <= d_addr;
                req_wdata_q <= d_wdata;
            end else if (if_req) begin
                req_we_q    <= 1'b0;
                req_sel_q   <= {SEL_W{1'b1}};
                req_addr_q  <= if_addr;
                req_wdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (last) begin
            if (state_q == ST_GNT_I)
                if_rdata_q <= mem_rdata;
            if (state_q == ST_GNT_D && !req_we_q)
                d_rdata_q <= mem_rdata;
        end
    end

    // Strobes decode straight from state so an async reset drops them
    // immediately rather than at the next edge.
    assign mem_ce    = in_gnt;
    assign mem_we    = in_gnt && req_we_q;
    assign mem_sel   = in_gnt ? req_sel_q : '0;
    assign mem_addr  = in_gnt ? req_addr_q : '0;
    assign mem_wdata = in_gnt ? req_wdata_q : '0;

    assign if_ack   = (state_q == ST_ACK_I);
    assign d_ack    = (state_q == ST_ACK_D);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign stall_o  = (if_req && !if_ack) || (d_req && !d_ack);

endmodule
